// File: rtl/vx_cache_perf_counter.sv
// Per-cache performance counter slot: popcounts raw event strobes into per-cycle
// deltas, then accumulates them into wrapping counters with clear/freeze control.
module vx_cache_perf_counter #(
  parameter int NUM_REQS      = 4,
  parameter int NUM_BANKS     = 4,
  parameter int PERF_CTR_BITS = 44,
  parameter bit ENABLE        = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     freeze,
  input  logic [NUM_REQS-1:0]      core_rd_fire,
  input  logic [NUM_REQS-1:0]      core_wr_fire,
  input  logic [NUM_REQS-1:0]      bank_stall,
  input  logic [NUM_REQS-1:0]      crsp_stall,
  input  logic [NUM_BANKS-1:0]     rd_miss,
  input  logic [NUM_BANKS-1:0]     wr_miss,
  input  logic [NUM_BANKS-1:0]     mshr_stall,
  input  logic                     mem_stall,
  output logic [PERF_CTR_BITS-1:0] perf_reads,
  output logic [PERF_CTR_BITS-1:0] perf_writes,
  output logic [PERF_CTR_BITS-1:0] perf_read_misses,
  output logic [PERF_CTR_BITS-1:0] perf_write_misses,
  output logic [PERF_CTR_BITS-1:0] perf_bank_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_mshr_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_mem_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_crsp_stalls
);

  localparam int REQ_CNT_W  = $clog2(NUM_REQS + 1);
  localparam int BANK_CNT_W = $clog2(NUM_BANKS + 1);

  function automatic logic [REQ_CNT_W-1:0] popcount_req(input logic [NUM_REQS-1:0] v);
    logic [REQ_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) cnt = cnt + REQ_CNT_W'(v[i]);
    return cnt;
  endfunction

  function automatic logic [BANK_CNT_W-1:0] popcount_bank(input logic [NUM_BANKS-1:0] v);
    logic [BANK_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) cnt = cnt + BANK_CNT_W'(v[i]);
    return cnt;
  endfunction

  // Modulo-2^PERF_CTR_BITS accumulate: all-ones rolls over to zero, no saturation.
  function automatic logic [PERF_CTR_BITS-1:0] acc_wrap(input logic [PERF_CTR_BITS-1:0] ctr,
                                                        input logic [PERF_CTR_BITS-1:0] delta);
    return ctr + delta;
  endfunction

  if (ENABLE) begin : g_on
    logic [REQ_CNT_W-1:0]     rd_delta_p0, wr_delta_p0, bank_delta_p0, crsp_delta_p0;
    logic [BANK_CNT_W-1:0]    rmiss_delta_p0, wmiss_delta_p0, mshr_delta_p0;
    logic                     mem_delta_p0;
    logic [PERF_CTR_BITS-1:0] reads_p1, writes_p1, rmiss_p1, wmiss_p1;
    logic [PERF_CTR_BITS-1:0] bank_p1, mshr_p1, mem_p1, crsp_p1;

    // Stage 0: per-cycle event deltas; freeze drops events rather than deferring them
    always_ff @(posedge clk) begin
      if (!reset || clear || freeze) begin
        rd_delta_p0    <= '0;
        wr_delta_p0    <= '0;
        bank_delta_p0  <= '0;
        crsp_delta_p0  <= '0;
        rmiss_delta_p0 <= '0;
        wmiss_delta_p0 <= '0;
        mshr_delta_p0  <= '0;
        mem_delta_p0   <= 1'b0;
      end else begin
        rd_delta_p0    <= popcount_req(core_rd_fire);
        wr_delta_p0    <= popcount_req(core_wr_fire);
        bank_delta_p0  <= popcount_req(bank_stall);
        crsp_delta_p0  <= popcount_req(crsp_stall);
        rmiss_delta_p0 <= popcount_bank(rd_miss);
        wmiss_delta_p0 <= popcount_bank(wr_miss);
        mshr_delta_p0  <= popcount_bank(mshr_stall);
        mem_delta_p0   <= mem_stall;
      end
    end

    // Stage 1: lockstep accumulation; during freeze the zeroed deltas make counters hold
    always_ff @(posedge clk) begin
      if (!reset || clear) begin
        reads_p1  <= '0;
        writes_p1 <= '0;
        rmiss_p1  <= '0;
        wmiss_p1  <= '0;
        bank_p1   <= '0;
        mshr_p1   <= '0;
        mem_p1    <= '0;
        crsp_p1   <= '0;
      end else begin
        reads_p1  <= acc_wrap(reads_p1,  PERF_CTR_BITS'(rd_delta_p0));
        writes_p1 <= acc_wrap(writes_p1, PERF_CTR_BITS'(wr_delta_p0));
        rmiss_p1  <= acc_wrap(rmiss_p1,  PERF_CTR_BITS'(rmiss_delta_p0));
        wmiss_p1  <= acc_wrap(wmiss_p1,  PERF_CTR_BITS'(wmiss_delta_p0));
        bank_p1   <= acc_wrap(bank_p1,   PERF_CTR_BITS'(bank_delta_p0));
        mshr_p1   <= acc_wrap(mshr_p1,   PERF_CTR_BITS'(mshr_delta_p0));
        mem_p1    <= acc_wrap(mem_p1,    PERF_CTR_BITS'(mem_delta_p0));
        crsp_p1   <= acc_wrap(crsp_p1,   PERF_CTR_BITS'(crsp_delta_p0));
      end
    end

    assign perf_reads        = reads_p1;
    assign perf_writes       = writes_p1;
    assign perf_read_misses  = rmiss_p1;
    assign perf_write_misses = wmiss_p1;
    assign perf_bank_stalls  = bank_p1;
    assign perf_mshr_stalls  = mshr_p1;
    assign perf_mem_stalls   = mem_p1;
    assign perf_crsp_stalls  = crsp_p1;
  end else begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, freeze, core_rd_fire, core_wr_fire, bank_stall,
                             crsp_stall, rd_miss, wr_miss, mshr_stall, mem_stall};

    assign perf_reads        = '0;
    assign perf_writes       = '0;
    assign perf_read_misses  = '0;
    assign perf_write_misses = '0;
    assign perf_bank_stalls  = '0;
    assign perf_mshr_stalls  = '0;
    assign perf_mem_stalls   = '0;
    assign perf_crsp_stalls  = '0;
  end

endmodule

// File: tb/tb_vx_cache_perf_counter.sv
// Bench for vx_cache_perf_counter: 8-bit, 44-bit and disabled instances share stimulus
// and are checked every cycle against an event-log reference model.
module tb_vx_cache_perf_counter;

  logic       clk;
  logic       reset, clear, freeze, mem_stall;
  logic [3:0] core_rd_fire, core_wr_fire, bank_stall, crsp_stall;
  logic [3:0] rd_miss, wr_miss, mshr_stall;

  logic [7:0]  o8   [8];
  logic [43:0] o44  [8];
  logic [43:0] ooff [8];

  int n_checks = 0;
  int n_errors = 0;

  string nm [8] = '{"reads", "writes", "rd_miss", "wr_miss", "bank", "mshr", "mem", "crsp"};

  typedef struct { int unsigned c [8]; } ev_t;
  ev_t log_q [$];

  vx_cache_perf_counter #(.PERF_CTR_BITS(8)) u_w8 (
    .clk(clk), .reset(reset), .clear(clear), .freeze(freeze),
    .core_rd_fire(core_rd_fire), .core_wr_fire(core_wr_fire), .bank_stall(bank_stall),
    .crsp_stall(crsp_stall), .rd_miss(rd_miss), .wr_miss(wr_miss), .mshr_stall(mshr_stall),
    .mem_stall(mem_stall),
    .perf_reads(o8[0]), .perf_writes(o8[1]), .perf_read_misses(o8[2]),
    .perf_write_misses(o8[3]), .perf_bank_stalls(o8[4]), .perf_mshr_stalls(o8[5]),
    .perf_mem_stalls(o8[6]), .perf_crsp_stalls(o8[7])
  );

  vx_cache_perf_counter u_w44 (
    .clk(clk), .reset(reset), .clear(clear), .freeze(freeze),
    .core_rd_fire(core_rd_fire), .core_wr_fire(core_wr_fire), .bank_stall(bank_stall),
    .crsp_stall(crsp_stall), .rd_miss(rd_miss), .wr_miss(wr_miss), .mshr_stall(mshr_stall),
    .mem_stall(mem_stall),
    .perf_reads(o44[0]), .perf_writes(o44[1]), .perf_read_misses(o44[2]),
    .perf_write_misses(o44[3]), .perf_bank_stalls(o44[4]), .perf_mshr_stalls(o44[5]),
    .perf_mem_stalls(o44[6]), .perf_crsp_stalls(o44[7])
  );

  vx_cache_perf_counter #(.ENABLE(1'b0)) u_off (
    .clk(clk), .reset(reset), .clear(clear), .freeze(freeze),
    .core_rd_fire(core_rd_fire), .core_wr_fire(core_wr_fire), .bank_stall(bank_stall),
    .crsp_stall(crsp_stall), .rd_miss(rd_miss), .wr_miss(wr_miss), .mshr_stall(mshr_stall),
    .mem_stall(mem_stall),
    .perf_reads(ooff[0]), .perf_writes(ooff[1]), .perf_read_misses(ooff[2]),
    .perf_write_misses(ooff[3]), .perf_bank_stalls(ooff[4]), .perf_mshr_stalls(ooff[5]),
    .perf_mem_stalls(ooff[6]), .perf_crsp_stalls(ooff[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a counter shows the sum of all events accepted since the last reset/clear,
  // excluding those of the most recent edge (one extra cycle of latency).
  task automatic model_edge();
    ev_t e;
    e.c[0] = $countones(core_rd_fire);
    e.c[1] = $countones(core_wr_fire);
    e.c[2] = $countones(rd_miss);
    e.c[3] = $countones(wr_miss);
    e.c[4] = $countones(bank_stall);
    e.c[5] = $countones(mshr_stall);
    e.c[6] = $countones(mem_stall);
    e.c[7] = $countones(crsp_stall);
    if (!reset || clear) log_q.delete();
    else begin
      if (freeze) for (int k = 0; k < 8; k++) e.c[k] = 0;
      log_q.push_back(e);
    end
  endtask

  function automatic logic [63:0] expv(input int k);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i + 1 < log_q.size(); i++) s += 64'(log_q[i].c[k]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s/w8", nm[k]), 64'(o8[k]), expv(k) & 64'hFF);
      chk($sformatf("%s/w44", nm[k]), 64'(o44[k]), expv(k) & 64'hFFF_FFFF_FFFF);
      chk($sformatf("%s/off", nm[k]), 64'(ooff[k]), 64'd0);
    end
  endtask

  task automatic zero_ev();
    core_rd_fire = '0; core_wr_fire = '0; bank_stall = '0; crsp_stall = '0;
    rd_miss = '0; wr_miss = '0; mshr_stall = '0; mem_stall = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b0; freeze = 1'b0;
    // Reset with all events asserted
    reset = 1'b0;
    core_rd_fire = '1; core_wr_fire = '1; bank_stall = '1; crsp_stall = '1;
    rd_miss = '1; wr_miss = '1; mshr_stall = '1; mem_stall = 1'b1;
    step(); step();
    chk("rst_reads", 64'(o44[0]), 64'd0);
    chk("rst_mem", 64'(o8[6]), 64'd0);
    reset = 1'b1;
    zero_ev();

    core_rd_fire = 4'b1011;
    step();
    step(); chk("tp_reads_3", 64'(o44[0]), 64'd3);
    step(); chk("tp_reads_6", 64'(o44[0]), 64'd6);
    core_rd_fire = '0;
    step(); chk("tp_reads_9", 64'(o44[0]), 64'd9);

    // Mixed vectors
    pulse_clear();
    rd_miss = 4'b1111; wr_miss = 4'b0001; mem_stall = 1'b1; crsp_stall = 4'b0110;
    step();
    zero_ev();
    step();
    chk("mix_rmiss", 64'(o44[2]), 64'd4);
    chk("mix_wmiss", 64'(o44[3]), 64'd1);
    chk("mix_mem",   64'(o44[6]), 64'd1);
    chk("mix_crsp",  64'(o44[7]), 64'd2);
    chk("mix_reads", 64'(o44[0]), 64'd0);

    // Wrap at 8 bits
    pulse_clear();
    core_wr_fire = 4'b1111;
    repeat (64) step();
    chk("wrap_252", 64'(o8[1]), 64'd252);
    core_wr_fire = 4'b0011;
    step(); chk("wrap_0", 64'(o8[1]), 64'd0);
    core_wr_fire = '0;
    step(); chk("wrap_2", 64'(o8[1]), 64'd2);
    chk("nowrap_258", 64'(o44[1]), 64'd258);

    // Clear discards the same-cycle events and the in-flight delta
    pulse_clear();
    bank_stall = 4'b1111; step(); step();
    bank_stall = 4'b0011; step();
    bank_stall = '0;      step(); chk("clr_acc10", 64'(o44[4]), 64'd10);
    bank_stall = 4'b1111; clear = 1'b1;
    step(); chk("clr_zero", 64'(o44[4]), 64'd0);
    clear = 1'b0; bank_stall = 4'b0001;
    step(); chk("clr_after0", 64'(o44[4]), 64'd0);
    bank_stall = '0;
    step(); chk("clr_after1", 64'(o44[4]), 64'd1);

    // Freeze keeps the pre-freeze delta, then holds; clear beats freeze
    pulse_clear();
    mshr_stall = 4'b0011;
    step();
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz_hold%0d", i), 64'(o44[5]), 64'd2);
    end
    clear = 1'b1;
    step(); chk("frz_clr", 64'(o44[5]), 64'd0);
    clear = 1'b0; freeze = 1'b0;
    step();
    step(); chk("frz_resume", 64'(o44[5]), 64'd2);
    zero_ev();

    // Randomised traffic with occasional reset, clear and freeze
    for (int n = 0; n < 300; n++) begin
      reset        = ($urandom_range(63) != 0);
      clear        = ($urandom_range(15) == 0);
      freeze       = ($urandom_range(7) == 0);
      core_rd_fire = 4'($urandom);
      core_wr_fire = 4'($urandom);
      bank_stall   = 4'($urandom);
      crsp_stall   = 4'($urandom);
      rd_miss      = 4'($urandom);
      wr_miss      = 4'($urandom);
      mshr_stall   = 4'($urandom);
      mem_stall    = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
